// File: rtl/cube_pkg.sv
// cube_pkg: geometry constants and types shared by conway_sim, the frame
// buffer and the LED-cube layer driver.
//   Cell index = z*64 + y*8 + x; a layer word holds bit y*8+x of plane z.
package cube_pkg;

    localparam int CUBE_DIM        = 8;
    localparam int CUBE_LAYERS     = 8;
    localparam int CELLS_PER_LAYER = CUBE_DIM * CUBE_DIM;
    localparam int CUBE_CELLS      = CUBE_LAYERS * CELLS_PER_LAYER;
    localparam int LAYER_W         = 3;
    localparam int CELL_IDX_W      = 9;

    typedef logic [LAYER_W-1:0]         layer_t;
    typedef logic [CELLS_PER_LAYER-1:0] layer_word_t;
    typedef logic [CUBE_CELLS-1:0]      cube_cells_t;

    // Index of the first cell of a layer inside a 512-bit generation.
    function automatic logic [CELL_IDX_W-1:0] layer_base(input layer_t layer);
        return {layer, {(CELL_IDX_W-LAYER_W){1'b0}}};
    endfunction

endpackage

// File: rtl/cube_scan_timer.sv
// cube_scan_timer: layer scan timing for the LED cube.
//   clk, rst_n    : clock, asynchronous active-low reset
//   layer         : layer currently presented (wraps 7 -> 0 forever)
//   frame_end     : combinational, high on the last tick of layer 7
//   frame_start   : registered one-cycle pulse on the first cycle of layer 0
//   blank         : high while tick < BLANK_TICKS (leading part of each dwell)
module cube_scan_timer
    import cube_pkg::*;
#(
    parameter int LAYER_TICKS = 4096,
    parameter int BLANK_TICKS = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    output layer_t layer,
    output logic   frame_end,
    output logic   frame_start,
    output logic   blank
);

    localparam int TICK_W = $clog2(LAYER_TICKS);

    logic [TICK_W-1:0] tick;
    logic              last_tick;

    assign last_tick = (tick == TICK_W'(LAYER_TICKS - 1));
    assign frame_end = last_tick && (layer == layer_t'(CUBE_LAYERS - 1));
    assign blank     = (tick < TICK_W'(BLANK_TICKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick        <= '0;
            layer       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (last_tick) begin
                tick  <= '0;
                layer <= layer + 1'b1;   // natural 3-bit wrap 7 -> 0
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cube_frame_buffer.sv
// cube_frame_buffer: double-buffered frame store between conway_sim and the
// LED-cube layer driver. A generation is captured into the back buffer and
// promoted to the front buffer only at a frame boundary, so a displayed
// frame never mixes two generations.
//   clk, rst_n   : clock, asynchronous active-low reset
//   cells_in     : 512-bit generation (index z*64 + y*8 + x)
//   gen_valid    : cells_in holds a new generation
//   gen_ready    : back buffer is free
//   layer_sel    : layer being presented
//   layer_data   : front word of layer_sel (bit y*8+x), zero latency
//   layer_valid  : layer_data may drive the LEDs
//   frame_start  : one-cycle pulse on the first cycle of layer 0
// Build option: define CUBE_FB_BLANK_EN to blank layer_valid for the first
// BLANK_TICKS cycles of every layer dwell.
module cube_frame_buffer
    import cube_pkg::*;
#(
    parameter int LAYER_TICKS = 4096,
    parameter int BLANK_TICKS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CUBE_CELLS-1:0] cells_in,
    input  logic                  gen_valid,
    output logic                  gen_ready,
    output layer_t                layer_sel,
    output layer_word_t           layer_data,
    output logic                  layer_valid,
    output logic                  frame_start
);

`ifdef CUBE_FB_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    cube_cells_t front;
    cube_cells_t back;
    logic        pending;
    logic        run_q;
    logic        frame_end;
    logic        blank;
    logic        capture;

    cube_scan_timer #(
        .LAYER_TICKS (LAYER_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_scan_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .layer       (layer_sel),
        .frame_end   (frame_end),
        .frame_start (frame_start),
        .blank       (blank)
    );

    // Handshake: a generation transfers on a rising edge where gen_valid and
    // gen_ready are both high. gen_ready is the inverse of a register only,
    // so it never depends combinationally on gen_valid; gen_valid while
    // gen_ready is low is simply ignored.
    assign gen_ready = ~pending;
    assign capture   = gen_valid && !pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front   <= '0;
            back    <= '0;
            pending <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            // Swap and capture are mutually exclusive: capture needs
            // pending=0, swap needs pending=1. A capture on the frame-end
            // edge therefore waits a whole frame before it is shown.
            if (frame_end && pending) begin
                front   <= back;
                pending <= 1'b0;
            end
            if (capture) begin
                back    <= cells_in;
                pending <= 1'b1;
            end
        end
    end

    assign layer_data  = front[layer_base(layer_sel) +: CELLS_PER_LAYER];
    assign layer_valid = run_q && !(BLANK_ON && blank);

endmodule

// File: tb/tb_cube_frame_buffer.sv
// Testbench for cube_frame_buffer with LAYER_TICKS=4, BLANK_TICKS=1
// (one frame = 32 cycles). Directed vector table, reset-in-frame sequence,
// then random generations checked against a cycle-count based model.
module tb_cube_frame_buffer;

    localparam int LT = 4;
    localparam int BT = 1;
    localparam int FRAME = 8 * LT;

    logic         clk;
    logic         rst_n;
    logic [511:0] cells_in;
    logic         gen_valid;
    logic         gen_ready;
    logic [2:0]   layer_sel;
    logic [63:0]  layer_data;
    logic         layer_valid;
    logic         frame_start;

    cube_frame_buffer #(
        .LAYER_TICKS (LT),
        .BLANK_TICKS (BT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cells_in    (cells_in),
        .gen_valid   (gen_valid),
        .gen_ready   (gen_ready),
        .layer_sel   (layer_sel),
        .layer_data  (layer_data),
        .layer_valid (layer_valid),
        .frame_start (frame_start)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Everything is derived from the number of edges since reset release.
    int           m_cyc;
    logic [511:0] m_front;
    logic [511:0] m_back;
    bit           m_pend;
    logic [63:0]  exp_q[$];

    int total;
    int bad;

    function automatic logic [511:0] mk(input int a, input int b);
        logic [511:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] front_word(input int cyc);
        int z;
        z = (cyc / LT) % 8;
        return m_front[z*64 +: 64];
    endfunction

    task automatic model_reset();
        m_cyc   = 0;
        m_front = '0;
        m_back  = '0;
        m_pend  = 0;
        exp_q.delete();
        exp_q.push_back(64'h0);
    endtask

    task automatic model_edge(input bit v, input logic [511:0] d);
        bit fe;
        bit cap;
        fe  = (m_cyc % FRAME) == FRAME - 1;
        cap = v && !m_pend;
        if (fe && m_pend) begin
            m_front = m_back;
            m_pend  = 0;
        end
        if (cap) begin
            m_back = d;
            m_pend = 1;
        end
        m_cyc++;
        exp_q.push_back(front_word(m_cyc));
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic [63:0] e_data;
        bit          e_valid;
        bit          e_fs;
        e_data = exp_q.pop_front();
        e_fs   = (m_cyc > 0) && (m_cyc % FRAME == 0);
`ifdef CUBE_FB_BLANK_EN
        e_valid = (m_cyc > 0) && ((m_cyc % LT) >= BT);
`else
        e_valid = (m_cyc > 0);
`endif
        chk("cyc_sel",   64'(layer_sel),   64'((m_cyc / LT) % 8));
        chk("cyc_data",  layer_data,       e_data);
        chk("cyc_fs",    64'(frame_start), 64'(e_fs));
        chk("cyc_valid", 64'(layer_valid), 64'(e_valid));
        chk("cyc_ready", 64'(gen_ready),   64'(!m_pend));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel"},   64'(layer_sel),   64'h0);
        chk({tag, "_data"},  layer_data,       64'h0);
        chk({tag, "_fs"},    64'(frame_start), 64'h0);
        chk({tag, "_valid"}, 64'(layer_valid), 64'h0);
        chk({tag, "_ready"}, 64'(gen_ready),   64'h1);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; drives inputs, lets one rising edge pass,
    // returns at the next falling edge after checking every output.
    task automatic drive_cycle(input bit v, input logic [511:0] d);
        gen_valid = v;
        cells_in  = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check_cycle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          adv;
        bit          valid;
        int          bit_a;
        int          bit_b;
        logic [2:0]  sel;
        bit          fs;
        bit          rdy;
        logic [63:0] data;
    } vec_t;

    localparam int NV = 18;
    vec_t vec[NV];

    initial begin
        total = 0;
        bad   = 0;

        // adv cycles with (valid, cells) applied, then expected outputs
        vec[0]  = '{8,  1'b0, -1,  -1,  3'd2, 1'b0, 1'b0 | 1'b1, 64'h0};
        vec[1]  = '{1,  1'b1,  0, 511,  3'd2, 1'b0, 1'b0, 64'h0};
        vec[2]  = '{22, 1'b0, -1,  -1,  3'd7, 1'b0, 1'b0, 64'h0};
        vec[3]  = '{1,  1'b0, -1,  -1,  3'd0, 1'b1, 1'b1, 64'h1};
        vec[4]  = '{1,  1'b0, -1,  -1,  3'd0, 1'b0, 1'b1, 64'h1};
        vec[5]  = '{27, 1'b0, -1,  -1,  3'd7, 1'b0, 1'b1, 64'h8000_0000_0000_0000};
        vec[6]  = '{4,  1'b0, -1,  -1,  3'd0, 1'b1, 1'b1, 64'h1};
        vec[7]  = '{1,  1'b1,  5,  -1,  3'd0, 1'b0, 1'b0, 64'h1};
        vec[8]  = '{10, 1'b1,  6,  -1,  3'd2, 1'b0, 1'b0, 64'h0};
        vec[9]  = '{20, 1'b1,  6,  -1,  3'd7, 1'b0, 1'b0, 64'h8000_0000_0000_0000};
        vec[10] = '{1,  1'b1,  6,  -1,  3'd0, 1'b1, 1'b1, 64'h20};
        vec[11] = '{1,  1'b1,  6,  -1,  3'd0, 1'b0, 1'b0, 64'h20};
        vec[12] = '{31, 1'b0, -1,  -1,  3'd0, 1'b1, 1'b1, 64'h40};
        vec[13] = '{31, 1'b0, -1,  -1,  3'd7, 1'b0, 1'b1, 64'h0};
        vec[14] = '{1,  1'b1, 64,  -1,  3'd0, 1'b1, 1'b0, 64'h40};
        vec[15] = '{4,  1'b0, -1,  -1,  3'd1, 1'b0, 1'b0, 64'h0};
        vec[16] = '{28, 1'b0, -1,  -1,  3'd0, 1'b1, 1'b1, 64'h0};
        vec[17] = '{4,  1'b0, -1,  -1,  3'd1, 1'b0, 1'b1, 64'h1};

        // ---- reset held for 5 cycles ----
        rst_n     = 1'b0;
        gen_valid = 1'b0;
        cells_in  = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
        model_reset();
        check_cycle();

        // ---- directed table: capture, backpressure, capture on frame end ----
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vec[i].adv; k++)
                drive_cycle(vec[i].valid, mk(vec[i].bit_a, vec[i].bit_b));
            chk($sformatf("vec%0d_sel", i),   64'(layer_sel),   64'(vec[i].sel));
            chk($sformatf("vec%0d_fs", i),    64'(frame_start), 64'(vec[i].fs));
            chk($sformatf("vec%0d_ready", i), 64'(gen_ready),   64'(vec[i].rdy));
            chk($sformatf("vec%0d_data", i),  layer_data,       vec[i].data);
        end

        // ---- asynchronous reset mid-frame with a generation pending ----
        drive_cycle(1'b1, mk(200, 300));
        for (int k = 0; k < 11; k++) drive_cycle(1'b0, '0);
        chk("pre_rst_sel",   64'(layer_sel), 64'h4);
        chk("pre_rst_ready", 64'(gen_ready), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold2");
        rst_n = 1'b1;
        model_reset();
        check_cycle();
        for (int k = 0; k < 2 * FRAME; k++) begin
            drive_cycle(1'b0, '0);
            chk("post_rst_data", layer_data, 64'h0);
        end

        // ---- randomized generations against the model ----
        for (int k = 0; k < 640; k++) begin
            logic [511:0] d;
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
            drive_cycle($urandom_range(0, 2) == 0, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
